// File: rtl/motion_pkg.sv
// motion_pkg: mode codes, FSM states and helpers shared by the
// motion sequencer and the code converter.
package motion_pkg;

   localparam logic [2:0] M_STOP = 3'd0;
   localparam logic [2:0] M_R_1X = 3'd1;
   localparam logic [2:0] M_R_2X = 3'd2;
   localparam logic [2:0] M_L_1X = 3'd3;
   localparam logic [2:0] M_L_2X = 3'd4;
   localparam logic [2:0] M_FWD  = 3'd5;
   localparam logic [2:0] M_REV  = 3'd6;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_GAP
   } state_e;

   // mode -> {lf, lr, rf, rr}
   function automatic logic [3:0] mode_wheels(input logic [2:0] m);
      logic [3:0] w;
      w = 4'b0000;
      case (m)
         M_R_1X:  w = 4'b1000;
         M_R_2X:  w = 4'b1001;
         M_L_1X:  w = 4'b0010;
         M_L_2X:  w = 4'b0110;
         M_FWD:   w = 4'b1010;
         M_REV:   w = 4'b0101;
         default: w = 4'b0000;
      endcase
      return w;
   endfunction

   // tick divisor: 5 for fast simulation, 5 Hz at 100 MHz otherwise
   function automatic int unsigned tick_div(input bit sim);
      return sim ? 32'd5 : 32'd19_999_999;
   endfunction

endpackage

// File: rtl/motion_sequencer_if.sv
// motion_sequencer_if: command push handshake (valid/ready + payload).
// master = host side, slave = sequencer side.
interface motion_sequencer_if #(
   parameter int DUR_W = 8
) ();
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_mode;
   logic [DUR_W-1:0] cmd_dur;

   modport master (
      output cmd_valid, cmd_mode, cmd_dur,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_mode, cmd_dur,
      output cmd_ready
   );
endinterface

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous show-ahead FIFO with push/pop/flush and count.
// Ports: clk, reset, push_i, pop_i, flush_i, wdata_i -> rdata_o, count_o.
module cmd_fifo #(
   parameter int W     = 11,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   input  logic [W-1:0]               wdata_i,
   output logic [W-1:0]               rdata_o,
   output logic [$clog2(DEPTH):0]     count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [AW:0]   cnt_q;
   logic          do_push;
   logic          do_pop;

   assign do_push = push_i && !flush_i && (cnt_q != FULL);
   assign do_pop  = pop_i && !flush_i && (cnt_q != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (flush_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (do_pop)  rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/motion_sequencer.sv
// motion_sequencer: plays queued {mode, duration} commands into the wheel
// drive outputs. Ports: clk, reset, cmd (slave handshake), start, abort,
// manual_en, man_wheels -> wheels, busy, done, cur_mode, fifo_count.
module motion_sequencer #(
   parameter int SIMULATE   = 0,
   parameter int FIFO_DEPTH = 8,
   parameter int DUR_W      = 8,
   parameter int GAP_TICKS  = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   motion_sequencer_if.slave             cmd,
   input  logic                          start,
   input  logic                          abort,
   input  logic                          manual_en,
   input  logic [3:0]                    man_wheels,
   output logic                          left_fwd,
   output logic                          left_rev,
   output logic                          right_fwd,
   output logic                          right_rev,
   output logic                          busy,
   output logic                          done,
   output logic [2:0]                    cur_mode,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
   import motion_pkg::*;

   localparam int CW  = $clog2(FIFO_DEPTH);
   localparam int DIV = int'(tick_div(SIMULATE != 0));
   localparam int DW  = $clog2(DIV + 1);
   localparam int GW  = $clog2(GAP_TICKS + 2);
   localparam logic [DW-1:0] DIV_L = DW'(DIV);
   localparam logic [GW-1:0] GAP_L = GW'(GAP_TICKS);
   localparam logic [CW:0]   FULL  = (CW+1)'(FIFO_DEPTH);

   state_e           state_q, state_d;
   logic [2:0]       mode_q, mode_d;
   logic [DUR_W-1:0] rem_q, rem_d;
   logic [GW-1:0]    gap_q, gap_d;
   logic [DW-1:0]    div_q, div_d;
   logic [3:0]       wheels_q, wheels_d;

   logic             push, pop, tick, fin, avail;
   logic [CW:0]      cnt, occ;
   logic [2:0]       head_mode;
   logic [DUR_W-1:0] head_dur;

   assign cmd.cmd_ready = !reset && (cnt != FULL) && !abort;
   assign push = cmd.cmd_valid && cmd.cmd_ready;
   assign pop  = (state_q == S_LOAD) && !manual_en && !abort;

   // occupancy after this cycle's push/pop decides LOAD vs IDLE
   assign occ   = cnt + (CW+1)'(push) - (CW+1)'(pop);
   assign avail = (occ != '0);

   assign tick = (state_q == S_RUN || state_q == S_GAP) && (div_q == DIV_L);

   cmd_fifo #(
      .W     (3 + DUR_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (abort),
      .wdata_i ({cmd.cmd_mode, cmd.cmd_dur}),
      .rdata_o ({head_mode, head_dur}),
      .count_o (cnt)
   );

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      rem_d   = rem_q;
      gap_d   = gap_q;
      fin     = 1'b0;
      if (abort) begin
         state_d = S_IDLE;
         mode_d  = M_STOP;
      end else if (!manual_en) begin
         unique case (state_q)
            S_IDLE: begin
               if (start && avail) state_d = S_LOAD;
            end
            S_LOAD: begin
               mode_d = head_mode;
               rem_d  = head_dur;
               if (head_dur != '0) begin
                  state_d = S_RUN;
               end else if (avail) begin
                  state_d = S_LOAD;
               end else begin
                  state_d = S_IDLE;
                  fin     = 1'b1;
               end
            end
            S_RUN: begin
               if (tick) begin
                  if (rem_q == DUR_W'(1)) begin
                     if (GAP_TICKS > 0) begin
                        state_d = S_GAP;
                        gap_d   = GAP_L;
                     end else if (avail) begin
                        state_d = S_LOAD;
                     end else begin
                        state_d = S_IDLE;
                        fin     = 1'b1;
                     end
                  end else if (rem_q != '0) begin
                     rem_d = rem_q - DUR_W'(1);
                  end
               end
            end
            S_GAP: begin
               if (tick) begin
                  if (gap_q <= GW'(1)) begin
                     if (avail) begin
                        state_d = S_LOAD;
                     end else begin
                        state_d = S_IDLE;
                        fin     = 1'b1;
                     end
                  end else begin
                     gap_d = gap_q - GW'(1);
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // divider restarts on every state change so RUN/GAP are whole ticks
   always_comb begin
      div_d = div_q;
      if (abort) begin
         div_d = '0;
      end else if (!manual_en) begin
         if (state_d != state_q) begin
            div_d = '0;
         end else if (state_q == S_RUN || state_q == S_GAP) begin
            div_d = tick ? '0 : div_q + DW'(1);
         end else begin
            div_d = '0;
         end
      end
   end

   always_comb begin
      wheels_d = 4'b0000;
      if (abort) begin
         wheels_d = 4'b0000;
      end else if (manual_en) begin
         wheels_d = man_wheels;
      end else if (state_q == S_RUN) begin
         wheels_d = mode_wheels(mode_q);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         mode_q   <= M_STOP;
         rem_q    <= '0;
         gap_q    <= '0;
         div_q    <= '0;
         wheels_q <= 4'b0000;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         rem_q    <= rem_d;
         gap_q    <= gap_d;
         div_q    <= div_d;
         wheels_q <= wheels_d;
      end
   end

   assign {left_fwd, left_rev, right_fwd, right_rev} = wheels_q;
   assign busy       = (state_q != S_IDLE);
   assign done       = fin;
   assign cur_mode   = (state_q == S_RUN) ? mode_q : M_STOP;
   assign fifo_count = cnt;

endmodule

// File: tb/tb_motion_sequencer.sv
// tb_motion_sequencer: random + directed stimulus against a cycle-count
// model of the motion sequencer (SIMULATE=1, GAP_TICKS=1).
module tb_motion_sequencer;

   localparam int DEPTH = 8;
   localparam int DUR_W = 8;
   localparam int GAPT  = 1;
   localparam int TP    = 6;

   localparam int P_IDLE = 0;
   localparam int P_LOAD = 1;
   localparam int P_RUN  = 2;
   localparam int P_GAP  = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       manual_en = 1'b0;
   logic [3:0] man_wheels = 4'b0000;
   logic       left_fwd, left_rev, right_fwd, right_rev;
   logic       busy, done;
   logic [2:0] cur_mode;
   logic [3:0] fifo_count;
   logic [3:0] w;

   motion_sequencer_if #(.DUR_W(DUR_W)) cmd_if ();

   motion_sequencer #(
      .SIMULATE   (1),
      .FIFO_DEPTH (DEPTH),
      .DUR_W      (DUR_W),
      .GAP_TICKS  (GAPT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd        (cmd_if),
      .start      (start),
      .abort      (abort),
      .manual_en  (manual_en),
      .man_wheels (man_wheels),
      .left_fwd   (left_fwd),
      .left_rev   (left_rev),
      .right_fwd  (right_fwd),
      .right_rev  (right_rev),
      .busy       (busy),
      .done       (done),
      .cur_mode   (cur_mode),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   assign w = {left_fwd, left_rev, right_fwd, right_rev};

   // model state
   int         m_phase;
   int         m_left;
   logic [2:0] m_mode;
   logic [3:0] m_wheels;
   logic [10:0] m_q [$];
   logic [3:0] WMAP [8] = '{4'b0000, 4'b1000, 4'b1001, 4'b0010,
                            4'b0110, 4'b1010, 4'b0101, 4'b0000};

   int n_tests = 0;
   int n_fail  = 0;
   int cyc_n   = 0;

   // observation statistics for directed checks
   int wcnt [16];
   int done_cnt, done_cyc, first_fwd, probe, probe_cnt, prev_cm, s_cyc;
   int runs [$];

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0d expected %0d",
                  name, cyc_n, act, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_phase  = P_IDLE;
      m_left   = 0;
      m_mode   = 3'd0;
      m_wheels = 4'b0000;
   endtask

   function automatic bit finish();
      if (m_q.size() > 0) begin
         m_phase = P_LOAD;
         return 1'b0;
      end
      m_phase = P_IDLE;
      return 1'b1;
   endfunction

   task automatic clear_stats();
      foreach (wcnt[i]) wcnt[i] = 0;
      done_cnt  = 0;
      done_cyc  = -1;
      first_fwd = -1;
      probe     = -1;
      probe_cnt = 0;
      prev_cm   = 0;
      runs.delete();
   endtask

   // one clock cycle: inputs already applied; check, step model, advance
   task automatic cyc();
      logic [3:0]  e_w;
      logic [10:0] head;
      int          e_cm, e_cnt;
      bit          e_busy, e_ready, e_done, psh;
      head = '0;
      #1;
      e_w     = m_wheels;
      e_busy  = (m_phase != P_IDLE);
      e_cm    = (m_phase == P_RUN) ? int'(m_mode) : 0;
      e_cnt   = m_q.size();
      e_ready = (m_q.size() != DEPTH) && !abort;
      psh     = cmd_if.cmd_valid && e_ready;
      e_done  = 1'b0;
      if (abort) begin
         m_q.delete();
         m_phase  = P_IDLE;
         m_wheels = 4'b0000;
      end else begin
         if (manual_en)             m_wheels = man_wheels;
         else if (m_phase == P_RUN) m_wheels = WMAP[m_mode];
         else                       m_wheels = 4'b0000;
         if (m_phase == P_LOAD && !manual_en) head = m_q.pop_front();
         if (psh) m_q.push_back({cmd_if.cmd_mode, cmd_if.cmd_dur});
         if (!manual_en) begin
            case (m_phase)
               P_IDLE: if (start && m_q.size() > 0) m_phase = P_LOAD;
               P_LOAD: begin
                  m_mode = head[10:8];
                  if (head[7:0] == 8'd0) begin
                     e_done = finish();
                  end else begin
                     m_phase = P_RUN;
                     m_left  = int'(head[7:0]) * TP;
                  end
               end
               P_RUN: begin
                  m_left--;
                  if (m_left == 0) begin
                     m_phase = P_GAP;
                     m_left  = GAPT * TP;
                  end
               end
               default: begin
                  m_left--;
                  if (m_left == 0) e_done = finish();
               end
            endcase
         end
      end
      chk("wheels",     int'(w),              int'(e_w));
      chk("busy",       int'(busy),           int'(e_busy));
      chk("done",       int'(done),           int'(e_done));
      chk("cur_mode",   int'(cur_mode),       e_cm);
      chk("fifo_count", int'(fifo_count),     e_cnt);
      chk("cmd_ready",  int'(cmd_if.cmd_ready), int'(e_ready));
      wcnt[w]++;
      if (done) begin
         done_cnt++;
         if (done_cyc < 0) done_cyc = cyc_n;
      end
      if (w == 4'b1010 && first_fwd < 0) first_fwd = cyc_n;
      if (cur_mode != 3'd0 && int'(cur_mode) != prev_cm)
         runs.push_back(int'(cur_mode));
      prev_cm = int'(cur_mode);
      if (busy && int'(cur_mode) == probe) probe_cnt++;
      @(posedge clk);
      #4;
      cyc_n++;
   endtask

   task automatic run(input int n);
      repeat (n) cyc();
   endtask

   task automatic push(input int mode, input int dur);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_mode  = 3'(mode);
      cmd_if.cmd_dur   = 8'(dur);
      cyc();
      cmd_if.cmd_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      s_cyc = cyc_n;
      cyc();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      int k;
      k = 0;
      while (busy && k < max) begin
         cyc();
         k++;
      end
      chk("idle_timeout", int'(busy), 0);
   endtask

   int exp_runs [8] = '{1, 2, 3, 4, 5, 6, 1, 2};

   initial begin
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_mode  = 3'd0;
      cmd_if.cmd_dur   = 8'd0;
      model_reset();
      clear_stats();
      #3;
      chk("rst_wheels", int'(w),                0);
      chk("rst_busy",   int'(busy),             0);
      chk("rst_done",   int'(done),             0);
      chk("rst_mode",   int'(cur_mode),         0);
      chk("rst_count",  int'(fifo_count),       0);
      chk("rst_ready",  int'(cmd_if.cmd_ready), 0);
      @(posedge clk);
      @(posedge clk);
      #4;
      reset = 1'b0;

      // 1: FWD for 3 ticks then one gap tick
      clear_stats();
      push(5, 3);
      pulse_start();
      run(30);
      chk("t1_fwd_cycles", wcnt[4'b1010], 18);
      chk("t1_latency",    first_fwd, s_cyc + 3);
      chk("t1_done_cnt",   done_cnt, 1);
      chk("t1_done_cyc",   done_cyc, s_cyc + 25);
      chk("t1_busy",       int'(busy), 0);

      // 2: overfill and FIFO order
      clear_stats();
      for (int i = 0; i < 9; i++) push((i % 6) + 1, 1);
      chk("t2_count", int'(fifo_count), 8);
      chk("t2_ready", int'(cmd_if.cmd_ready), 0);
      pulse_start();
      wait_idle(300);
      chk("t2_nruns", runs.size(), 8);
      for (int i = 0; i < 8; i++)
         chk("t2_order", (i < runs.size()) ? runs[i] : -1, exp_runs[i]);

      // 3: zero-duration command is skipped
      clear_stats();
      push(3, 1);
      push(5, 0);
      push(6, 1);
      pulse_start();
      wait_idle(100);
      chk("t3_l1x", wcnt[4'b0010], 6);
      chk("t3_rev", wcnt[4'b0101], 6);
      chk("t3_fwd", wcnt[4'b1010], 0);

      // 4: abort during RUN, push in the abort cycle dropped
      clear_stats();
      push(5, 5);
      push(5, 5);
      push(5, 5);
      pulse_start();
      run(8);
      abort = 1'b1;
      cmd_if.cmd_valid = 1'b1;
      cyc();
      abort = 1'b0;
      cmd_if.cmd_valid = 1'b0;
      chk("t4_wheels", int'(w), 0);
      chk("t4_count",  int'(fifo_count), 0);
      chk("t4_busy",   int'(busy), 0);
      run(20);
      chk("t4_done", done_cnt, 0);

      // 5: manual override freezes a REV run
      clear_stats();
      probe = 6;
      push(6, 2);
      pulse_start();
      run(4);
      manual_en  = 1'b1;
      man_wheels = 4'b1001;
      run(10);
      manual_en  = 1'b0;
      wait_idle(100);
      chk("t5_run_cycles", probe_cnt, 22);
      chk("t5_manual",     wcnt[4'b1001], 10);
      chk("t5_rev",        wcnt[4'b0101], 12);

      // 6: mode 111 drives nothing; async reset mid-RUN
      clear_stats();
      probe = 7;
      push(7, 2);
      push(5, 3);
      push(1, 1);
      pulse_start();
      run(14);
      chk("t6_run_cycles", probe_cnt, 12);
      chk("t6_zero",       wcnt[4'b0000], 18);
      run(10);
      #2;
      reset = 1'b1;
      #1;
      chk("t6_rst_wheels", int'(w),                0);
      chk("t6_rst_busy",   int'(busy),             0);
      chk("t6_rst_mode",   int'(cur_mode),         0);
      chk("t6_rst_count",  int'(fifo_count),       0);
      chk("t6_rst_ready",  int'(cmd_if.cmd_ready), 0);
      @(posedge clk);
      #4;
      reset = 1'b0;
      model_reset();

      // random traffic
      for (int i = 0; i < 2500; i++) begin
         cmd_if.cmd_valid = ($urandom_range(0, 99) < 45);
         cmd_if.cmd_mode  = 3'($urandom_range(0, 7));
         cmd_if.cmd_dur   = 8'($urandom_range(0, 3));
         start      = ($urandom_range(0, 99) < 10);
         abort      = ($urandom_range(0, 99) < 1);
         if ($urandom_range(0, 99) < 4) manual_en = !manual_en;
         man_wheels = 4'($urandom_range(0, 15));
         cyc();
      end
      cmd_if.cmd_valid = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      manual_en = 1'b0;
      run(5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
